// File: rtl/alu_exec_unit.sv
// Registered, handshaked 20-bit ALU execute stage that also holds the architectural {T,C,S,Z} status.
// Define ALU_TRAP_EN to make illegal opcodes set a sticky trap bit that halts issue until LSR/XSR.
module alu_exec_unit #(
  parameter int WIDTH = 20,
  parameter int HALF  = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [4:0]       op,
  input  logic             mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] res_a,
  output logic [WIDTH-1:0] res_b,
  output logic [3:0]       status
);

  localparam logic [4:0] OP_NOT  = 5'd0;
  localparam logic [4:0] OP_AND  = 5'd1;
  localparam logic [4:0] OP_OR   = 5'd2;
  localparam logic [4:0] OP_XOR  = 5'd3;
  localparam logic [4:0] OP_SHR  = 5'd4;
  localparam logic [4:0] OP_SHL  = 5'd5;
  localparam logic [4:0] OP_ROR  = 5'd6;
  localparam logic [4:0] OP_ROL  = 5'd7;
  localparam logic [4:0] OP_SWAP = 5'd8;
  localparam logic [4:0] OP_INC  = 5'd9;
  localparam logic [4:0] OP_DEC  = 5'd10;
  localparam logic [4:0] OP_ADD  = 5'd11;
  localparam logic [4:0] OP_ADC  = 5'd12;
  localparam logic [4:0] OP_SUB  = 5'd13;
  localparam logic [4:0] OP_SBC  = 5'd14;
  localparam logic [4:0] OP_EQ   = 5'd15;
  localparam logic [4:0] OP_GT   = 5'd16;
  localparam logic [4:0] OP_LT   = 5'd17;
  localparam logic [4:0] OP_GE   = 5'd18;
  localparam logic [4:0] OP_LE   = 5'd19;
  localparam logic [4:0] OP_LSR  = 5'd20;
  localparam logic [4:0] OP_XSR  = 5'd21;
  localparam logic [4:0] OP_NOP  = 5'd22;

  localparam logic [WIDTH-1:0] HALF_MASK = {{(WIDTH-HALF){1'b0}}, {HALF{1'b1}}};
  localparam logic [WIDTH-1:0] ZERO_W    = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONE_W     = {{(WIDTH-1){1'b0}}, 1'b1};

  logic             out_free;
  logic             accept;
  logic [WIDTH-1:0] mask;
  logic [WIDTH-1:0] am;
  logic [WIDTH-1:0] bm;
  logic             msb;
  logic             cin;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   diff;
  logic             carry;
  logic             borrow;
  logic [WIDTH-1:0] lsb_top;
  logic [WIDTH-1:0] not_res;
  logic [WIDTH-1:0] and_res;
  logic [WIDTH-1:0] or_res;
  logic [WIDTH-1:0] xor_res;
  logic [WIDTH-1:0] shr_res;
  logic [WIDTH-1:0] shl_res;
  logic [WIDTH-1:0] ror_res;
  logic [WIDTH-1:0] rol_res;
  logic [WIDTH-1:0] inc_res;
  logic [WIDTH-1:0] dec_res;
  logic [WIDTH-1:0] add_res;
  logic [WIDTH-1:0] sub_res;
  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [3:0]       nxt_status;

  assign out_free = !out_valid || out_ready;

`ifdef ALU_TRAP_EN
  logic is_sr_op;
  assign is_sr_op = (op == OP_LSR) || (op == OP_XSR);
  assign in_ready = out_free && (!status[3] || is_sr_op);
`else
  assign in_ready = out_free;
`endif

  assign accept = in_valid && in_ready;

  // Operands are masked to the active width once, so every datapath below works at W.
  assign mask = mode ? {WIDTH{1'b1}} : HALF_MASK;
  assign am   = a & mask;
  assign bm   = b & mask;
  assign msb  = mode ? am[WIDTH-1] : am[HALF-1];
  assign cin  = ((op == OP_ADC) || (op == OP_SBC)) ? status[2] : 1'b0;

  // Half-word sums never reach bit WIDTH, so the carry is picked at bit HALF; a borrow sign-fills, so bit WIDTH serves both.
  assign sum    = {1'b0, am} + {1'b0, bm} + {{WIDTH{1'b0}}, cin};
  assign diff   = {1'b0, am} - {1'b0, bm} - {{WIDTH{1'b0}}, cin};
  assign carry  = mode ? sum[WIDTH] : sum[HALF];
  assign borrow = diff[WIDTH];

  assign lsb_top = mode ? {am[0], {(WIDTH-1){1'b0}}}
                        : {{(WIDTH-HALF){1'b0}}, am[0], {(HALF-1){1'b0}}};

  assign not_res = ~am & mask;
  assign and_res = am & bm;
  assign or_res  = am | bm;
  assign xor_res = am ^ bm;
  assign shr_res = {1'b0, am[WIDTH-1:1]};
  assign shl_res = {am[WIDTH-2:0], 1'b0} & mask;
  assign ror_res = shr_res | lsb_top;
  assign rol_res = shl_res | {{(WIDTH-1){1'b0}}, msb};
  assign inc_res = (am + ONE_W) & mask;
  assign dec_res = (am - ONE_W) & mask;
  assign add_res = sum[WIDTH-1:0] & mask;
  assign sub_res = diff[WIDTH-1:0] & mask;

  // Opcode decode: result selection and next status value.
  always_comb begin
    alu_a      = ZERO_W;
    alu_b      = ZERO_W;
    nxt_status = status;
    case (op)
      OP_NOT:  begin alu_a = not_res; nxt_status[0] = ~|not_res; end
      OP_AND:  begin alu_a = and_res; nxt_status[0] = ~|and_res; end
      OP_OR:   begin alu_a = or_res;  nxt_status[0] = ~|or_res;  end
      OP_XOR:  begin alu_a = xor_res; nxt_status[0] = ~|xor_res; end
      OP_SHR:  begin alu_a = shr_res; nxt_status[2] = am[0]; nxt_status[0] = ~|shr_res; end
      OP_SHL:  begin alu_a = shl_res; nxt_status[2] = msb;   nxt_status[0] = ~|shl_res; end
      OP_ROR:  alu_a = ror_res;
      OP_ROL:  alu_a = rol_res;
      OP_SWAP: begin alu_a = bm; alu_b = am; end
      OP_INC:  begin alu_a = inc_res; nxt_status[0] = ~|inc_res; end
      OP_DEC:  begin alu_a = dec_res; nxt_status[0] = ~|dec_res; end
      OP_ADD,
      OP_ADC:  begin alu_a = add_res; nxt_status[2] = carry;  nxt_status[0] = ~|add_res; end
      OP_SUB,
      OP_SBC:  begin alu_a = sub_res; nxt_status[2] = borrow; nxt_status[0] = ~|sub_res; end
      OP_EQ:   nxt_status[0] = (am == bm);
      OP_GT:   nxt_status[1] = (am > bm);
      OP_LT:   nxt_status[1] = (am < bm);
      OP_GE:   begin nxt_status[1] = (am > bm); nxt_status[0] = (am == bm); end
      OP_LE:   begin nxt_status[1] = (am < bm); nxt_status[0] = (am == bm); end
      OP_LSR:  nxt_status = a[3:0];
      OP_XSR:  nxt_status = status ^ a[3:0];
      OP_NOP:  nxt_status = status;
      default: begin
`ifdef ALU_TRAP_EN
        nxt_status[3] = 1'b1;
`else
        nxt_status = status;
`endif
      end
    endcase
  end

  // Output/status register: load on accept, drop the beat once the consumer takes it.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      res_a     <= ZERO_W;
      res_b     <= ZERO_W;
      status    <= 4'b0000;
    end else if (accept) begin
      out_valid <= 1'b1;
      res_a     <= alu_a;
      res_b     <= alu_b;
      status    <= nxt_status;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: doc/alu_exec_unit.md
Name: alu_exec_unit

Overview:
- Registered, handshaked execute stage that issues operations to the 20-bit ALU operation circuits and collects their results and flags.
- Keeps the architectural status register (Z, S, C, T) that the program-flow instructions read: jumps, Load Status Register, XOR Status Register.
- Sits between the decode stage, on the upstream valid/ready side, and writeback, on the downstream valid/ready side.

Parameters:
- WIDTH, 20, full-word operand width.
- HALF, 10, half-word width: the active width when mode=0.

Ports:
- clk  in  1  system clock, rising-edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  request present.
- in_ready  out  1  request accepted on the cycle when in_valid&&in_ready.
- op  in  5  opcode (see Behaviour).
- mode  in  1  1 = full-word, 0 = half-word.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- out_valid  out  1  result held.
- out_ready  in  1  consumer takes the result on out_valid&&out_ready.
- res_a  out  WIDTH  primary result.
- res_b  out  WIDTH  second result (SWAP only, else 0).
- status  out  4  {T,C,S,Z} = bits [3:0]; T=bit3, C=bit2, S=bit1, Z=bit0.

Behaviour:
- Reset: in_ready=1, out_valid=0, res_a=0, res_b=0, status=0. A reset mid-operation drops any held result, and no flag update survives it.
- Handshake:
  - in_ready = !out_valid || out_ready (combinational).
  - On accept, res_a/res_b/out_valid=1 are registered, giving 1-cycle latency.
  - Outputs hold stable while out_valid&&!out_ready.
  - Simultaneous drain and accept sustains 1 op/cycle.
- Status register: updated on the accept edge. A back-to-back ADC/SBC therefore uses the C produced by the immediately preceding op.
- Active width:
  - W = WIDTH if mode=1, else HALF.
  - In half-word mode only a[HALF-1:0] and b[HALF-1:0] are used; result bits above HALF-1 are 0.
  - Carry, zero and MSB are taken at the active width.
- Opcodes (res_a; flag updates; unlisted flags unchanged):
  - 0 NOT: ~a; Z.
  - 1 AND, 2 OR, 3 XOR: Z.
  - 4 SHR: a>>1; C=a[0]; Z.
  - 5 SHL: a<<1; C=a[W-1]; Z.
  - 6 ROR, 7 ROL: rotate by 1 within W; no flags.
  - 8 SWAP: res_a=b, res_b=a; no flags.
  - 9 INC, 10 DEC: wrap at W; Z.
  - 11 ADD: a+b; C=carry out of bit W-1; Z.
  - 12 ADC: a+b+C; C; Z.
  - 13 SUB: a-b; C=borrow; Z.
  - 14 SBC: a-b-C; C=borrow; Z.
  - 15 EQ: Z=(a==b).
  - 16 GT: S=(a>b).
  - 17 LT: S=(a<b).
  - 18 GE: S=(a>b), Z=(a==b).
  - 19 LE: S=(a<b), Z=(a==b).
  - 20 LSR: status<=a[3:0].
  - 21 XSR: status<=status^a[3:0].
  - 22 NOP: no change.
  - Compares are unsigned at W. Compare, LSR, XSR and NOP produce res_a=0.
- Illegal opcodes (23-31): res_a=0; see the optional feature.
- Every accepted op, including NOP, produces exactly one out_valid beat.

Optional Feature:
- ALU_TRAP_EN defined: an illegal opcode sets T=1 (trap mode).
  - T is sticky; only LSR, XSR or rst change it.
  - While T=1, in_ready=0, which halts issue, except that LSR/XSR requests are still accepted when the output is free.
- Undefined: illegal opcodes behave exactly as NOP, T is never set by hardware, and LSR/XSR write bit3 normally.

Test Plan:
- Reset: rst high 2 cycles with in_valid=1 -> out_valid=0, status=4'b0000, in_ready=1 after release.
- Full-word carry chain:
  - ADD a=20'hFFFFF, b=1, mode=1 -> res_a=0, Z=1, C=1.
  - Next-cycle ADC a=0, b=0 -> res_a=1, C=0, Z=0.
  - 2 results on consecutive cycles.
- Half-word masking: ADD a=20'hFF3FF, b=1, mode=0 -> res_a=20'h00000, Z=1, C=1. SHL a=20'h00200, mode=0 -> res_a=0, C=1.
- Backpressure: out_ready=0 for 3 cycles after SUB 5-7 -> in_ready=0, res_a=20'hFFFFE held stable, C=1; out_ready=1 -> one beat, next op accepted same cycle.
- Compare/status ops:
  - GE a=7, b=7 -> Z=1, S=0.
  - LSR a=4'b0110 -> status=4'b0110.
  - XSR a=4'b0011 -> status=4'b0101.
  - SWAP a=1, b=2 -> res_a=2, res_b=1.
- Trap (ALU_TRAP_EN): op=25 -> T=1, in_ready=0 for ADD; LSR a=0 accepted -> status=0, issue resumes. Without the macro, op=25 -> status unchanged, res_a=0.
